ifu_fetch_bus: RTL and testbench

//  Upstream instruction-fetch bus master for the pipelined IFU: one AXI4-Lite read per PC.

---
 rtl/ifu_fetch_bus.sv | 141 ++++++++++++++
 tb/tb_ifu_fetch_bus.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_bus.sv
// rtl/ifu_fetch_bus.sv - AXI4-Lite instruction fetch master, one read per PC
// Optional abandon-on-timeout enabled by defining FETCH_TIMEOUT_EN.
module ifu_fetch_bus #(
`ifdef FETCH_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 255,
`endif
  parameter logic [31:0] ERR_INSTR = 32'h00100073
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [63:0] pc,
  input  logic        backend_ready,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        rdata_valid,
  output logic        update,
  output logic        fetch_err,
  output logic [63:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_WAIT} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_held;
  logic        r_fetch_err;
  logic        w_load;
  logic [31:0] w_load_word;
  logic        w_set_err;
  logic        w_timeout;
  logic        w_misaligned;
  logic [31:0] w_beat_word;

  assign araddr       = {pc[63:3], 3'b000};
  assign fetch_err    = r_fetch_err;
  assign w_misaligned = (pc[1:0] != 2'b00);
  assign w_beat_word  = pc[2] ? rdata[63:32] : rdata[31:0];

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] r_cnt;

  // The cycle in which the count reaches TIMEOUT_CYCLES-1 is the last one spent in AR/R.
  assign w_timeout = ((r_state == S_AR) || (r_state == S_R)) &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (((r_state == S_AR) || (r_state == S_R)) &&
                 !((r_state == S_R) && (w_next == S_AR))) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_held      <= 32'h0;
      r_fetch_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load)    r_held      <= w_load_word;
      if (w_set_err) r_fetch_err <= 1'b1;
    end
  end

  always_comb begin
    w_next      = r_state;
    arvalid     = 1'b0;
    rready      = 1'b0;
    update      = 1'b0;
    instr_valid = 1'b0;
    rdata_valid = 1'b0;
    instr       = r_held;
    w_load      = 1'b0;
    w_load_word = r_held;
    w_set_err   = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_AR;
      S_AR: begin
        if (w_misaligned || w_timeout) begin
          instr       = ERR_INSTR;
          instr_valid = 1'b1;
          w_load      = 1'b1;
          w_load_word = ERR_INSTR;
          w_set_err   = 1'b1;
          w_next      = S_WAIT;
        end else begin
          arvalid = 1'b1;
          if (arready) w_next = S_R;
        end
      end
      S_R: begin
        if (w_timeout) begin
          instr       = ERR_INSTR;
          instr_valid = 1'b1;
          w_load      = 1'b1;
          w_load_word = ERR_INSTR;
          w_set_err   = 1'b1;
          w_next      = S_WAIT;
        end else begin
          rready = 1'b1;
          if (rvalid) begin
            w_load_word = (rresp != 2'b00) ? ERR_INSTR : w_beat_word;
            w_set_err   = (rresp != 2'b00);
            w_load      = 1'b1;
            instr       = w_load_word;
            instr_valid = 1'b1;
            if (backend_ready) begin
              update = 1'b1;
              w_next = S_AR;
            end else begin
              w_next = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        rdata_valid = 1'b1;
        if (backend_ready) begin
          update = 1'b1;
          w_next = S_AR;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ifu_fetch_bus.sv
// tb/tb_ifu_fetch_bus.sv - directed self-checking bench for ifu_fetch_bus
module tb_ifu_fetch_bus;

  logic        clk = 1'b0;
  logic        rstn;
  logic [63:0] pc;
  logic        backend_ready;
  logic [31:0] instr;
  logic        instr_valid;
  logic        rdata_valid;
  logic        update;
  logic        fetch_err;
  logic [63:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] EBREAK = 32'h00100073;

  always #5 clk = ~clk;

`ifdef FETCH_TIMEOUT_EN
  ifu_fetch_bus #(.TIMEOUT_CYCLES(8)) dut (
`else
  ifu_fetch_bus dut (
`endif
    .clk(clk), .rstn(rstn), .pc(pc), .backend_ready(backend_ready),
    .instr(instr), .instr_valid(instr_valid), .rdata_valid(rdata_valid),
    .update(update), .fetch_err(fetch_err), .araddr(araddr), .arvalid(arvalid),
    .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; pc = 64'h0; backend_ready = 1'b0; arready = 1'b0;
    rdata = 64'h0; rresp = 2'b00; rvalid = 1'b0;
    step(); step();
    chk("rst_arvalid", {63'h0, arvalid}, 64'h0);
    chk("rst_rready", {63'h0, rready}, 64'h0);
    chk("rst_update", {63'h0, update}, 64'h0);
    chk("rst_instr_valid", {63'h0, instr_valid}, 64'h0);
    chk("rst_rdata_valid", {63'h0, rdata_valid}, 64'h0);
    chk("rst_fetch_err", {63'h0, fetch_err}, 64'h0);
    chk("rst_instr", {32'h0, instr}, 64'h0);

    // Test 1: immediate handshake, backend ready
    pc = 64'h8000_0000; arready = 1'b1; backend_ready = 1'b1; rstn = 1'b1;
    #1;
    chk("t1_idle_arvalid", {63'h0, arvalid}, 64'h0);
    step();
    chk("t1_arvalid", {63'h0, arvalid}, 64'h1);
    chk("t1_araddr", araddr, 64'h8000_0000);
    step();
    arready = 1'b0; rvalid = 1'b1; rdata = 64'h11111111_00000413; #1;
    chk("t1_rready", {63'h0, rready}, 64'h1);
    chk("t1_instr", {32'h0, instr}, 64'h0000_0413);
    chk("t1_instr_valid", {63'h0, instr_valid}, 64'h1);
    chk("t1_update", {63'h0, update}, 64'h1);
    step();

    // Test 2: upper word, backend stalls 3 WAIT cycles
    pc = 64'h8000_0004; rvalid = 1'b0; arready = 1'b1; backend_ready = 1'b0; #1;
    chk("t2_arvalid", {63'h0, arvalid}, 64'h1);
    chk("t2_araddr", araddr, 64'h8000_0000);
    step();
    arready = 1'b0; rvalid = 1'b1; #1;
    chk("t2_instr", {32'h0, instr}, 64'h1111_1111);
    chk("t2_instr_valid", {63'h0, instr_valid}, 64'h1);
    chk("t2_no_update", {63'h0, update}, 64'h0);
    step();
    rvalid = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("t2_wait_rdv", {63'h0, rdata_valid}, 64'h1);
      chk("t2_wait_iv", {63'h0, instr_valid}, 64'h0);
      chk("t2_wait_instr", {32'h0, instr}, 64'h1111_1111);
      chk("t2_wait_upd", {63'h0, update}, 64'h0);
      step();
    end
    backend_ready = 1'b1; #1;
    chk("t2_w4_rdv", {63'h0, rdata_valid}, 64'h1);
    chk("t2_w4_update", {63'h0, update}, 64'h1);
    step();

    // Test 3: arready held low 5 cycles
    pc = 64'h8000_0008; arready = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_arvalid", {63'h0, arvalid}, 64'h1);
      chk("t3_araddr", araddr, 64'h8000_0008);
      chk("t3_update", {63'h0, update}, 64'h0);
      step();
    end
    arready = 1'b1; #1;
    chk("t3_arvalid6", {63'h0, arvalid}, 64'h1);
    step();
    arready = 1'b0; rvalid = 1'b1; rdata = 64'hdeadbeef_00100093; #1;
    chk("t3_instr", {32'h0, instr}, 64'h0010_0093);
    chk("t3_update", {63'h0, update}, 64'h1);
    step();

    // Test 4: error response is sticky
    pc = 64'h8000_000c; rvalid = 1'b0; arready = 1'b1; #1;
    chk("t4_araddr", araddr, 64'h8000_0008);
    step();
    arready = 1'b0; rvalid = 1'b1; rresp = 2'b10; #1;
    chk("t4_instr", {32'h0, instr}, {32'h0, EBREAK});
    chk("t4_instr_valid", {63'h0, instr_valid}, 64'h1);
    step();
    pc = 64'h8000_0010; rvalid = 1'b0; rresp = 2'b00; arready = 1'b1; #1;
    chk("t4_err_set", {63'h0, fetch_err}, 64'h1);
    step();
    arready = 1'b0; rvalid = 1'b1; rdata = 64'h0_00000013; #1;
    chk("t4_next_instr", {32'h0, instr}, 64'h0000_0013);
    step();
    rvalid = 1'b0;
    chk("t4_err_sticky", {63'h0, fetch_err}, 64'h1);

    // Test 5: misaligned PC never issues AR
    pc = 64'h8000_0002; backend_ready = 1'b0; #1;
    chk("t5_arvalid", {63'h0, arvalid}, 64'h0);
    step();
    chk("t5_rdv", {63'h0, rdata_valid}, 64'h1);
    chk("t5_instr", {32'h0, instr}, {32'h0, EBREAK});
    chk("t5_err", {63'h0, fetch_err}, 64'h1);
    backend_ready = 1'b1; #1;
    chk("t5_update", {63'h0, update}, 64'h1);
    step();

    // Test 6: reset in the middle of R
    pc = 64'h8000_0018; arready = 1'b1; #1;
    step();
    chk("t6_in_r", {63'h0, rready}, 64'h1);
    rstn = 1'b0;
    step();
    rstn = 1'b1; arready = 1'b0; #1;
    chk("t6_arvalid", {63'h0, arvalid}, 64'h0);
    chk("t6_rready", {63'h0, rready}, 64'h0);
    chk("t6_update", {63'h0, update}, 64'h0);
    chk("t6_iv", {63'h0, instr_valid}, 64'h0);
    chk("t6_rdv", {63'h0, rdata_valid}, 64'h0);
    chk("t6_err", {63'h0, fetch_err}, 64'h0);
    chk("t6_instr", {32'h0, instr}, 64'h0);
    step();
    chk("t6_idle_to_ar", {63'h0, arvalid}, 64'h1);

`ifdef FETCH_TIMEOUT_EN
    // Timeout of 8 cycles in AR/R with no beat ever arriving
    arready = 1'b1; rvalid = 1'b0;
    step();
    arready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("to_pending_err", {63'h0, fetch_err}, 64'h0);
      chk("to_pending_rready", {63'h0, rready}, 64'h1);
      step();
    end
    chk("to_last_rready", {63'h0, rready}, 64'h0);
    chk("to_last_err", {63'h0, fetch_err}, 64'h0);
    step();
    rvalid = 1'b1; backend_ready = 1'b0; #1;
    chk("to_err", {63'h0, fetch_err}, 64'h1);
    chk("to_rdv", {63'h0, rdata_valid}, 64'h1);
    chk("to_instr", {32'h0, instr}, {32'h0, EBREAK});
    chk("to_late_beat", {63'h0, instr_valid}, 64'h0);
    rvalid = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
